// File: rtl/arp_frame_generator_param_pkg.sv
// Shared constants, types and the byte-wide CRC-32 step used by the ARP frame generator.
// CRC arithmetic is in the reflected (LSB-first) form that Ethernet transmits.
package arp_frame_generator_param_pkg;

  typedef logic [47:0] mac_address;
  typedef logic [31:0] ip_address;
  typedef logic [15:0] arp_operator;
  typedef logic [15:0] vlan_tci_t;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;
  localparam logic [15:0] ARP_HTYPE      = 16'h0001;
  localparam logic [15:0] ARP_PTYPE      = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'h06;
  localparam logic [7:0]  ARP_PLEN       = 8'h04;

  localparam int MIN_FRAME_NOFCS = 60;
  localparam int ARP_BODY_BYTES  = 28;
  localparam int FCS_BYTES       = 4;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_HDR,
    ST_ARP,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } arp_state_e;

  // One byte of reflected CRC-32; 0x04C11DB7 bit-reversed is 0xEDB88320.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/arp_frame_generator_param_fcs_gen.sv
// Byte-wide CRC-32 accumulator: clear reloads the seed, enable folds in one byte per cycle.
// fcs_byte presents the complemented register, byte idx 0 being the first on the wire.
module arp_frame_generator_param_fcs_gen
  import arp_frame_generator_param_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  input  logic [1:0] idx,
  output logic [7:0] fcs_byte
);

  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc32_step(crc_q, data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign fcs = ~crc_q;

  always_comb begin
    fcs_byte = fcs[7:0];
    case (idx)
      2'd0: fcs_byte = fcs[7:0];
      2'd1: fcs_byte = fcs[15:8];
      2'd2: fcs_byte = fcs[23:16];
      2'd3: fcs_byte = fcs[31:24];
      default: fcs_byte = fcs[7:0];
    endcase
  end

endmodule

// File: rtl/arp_frame_generator_param.sv
// Complete Ethernet II ARP frame source on a GMII byte interface (preamble to FCS, then gap).
// Handshake: req is a level; it is taken when the generator is idle (or on the final gap cycle),
// busy rises on the accepting edge and stays high through the last gap cycle, done pulses once.
module arp_frame_generator_param
  import arp_frame_generator_param_pkg::*;
#(
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned IFG_BYTES      = 12,
  parameter bit          VLAN_EN        = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] operator,
  input  logic [47:0] src_mac_add,
  input  logic [47:0] des_mac_add,
  input  logic [31:0] src_ip_add,
  input  logic [31:0] des_ip_add,
  input  logic [15:0] vlan_tci,
  output logic        busy,
  output logic        done,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_er
);

  localparam int HDR_LEN = VLAN_EN ? 18 : 14;
  localparam int PAD_LEN = MIN_FRAME_NOFCS - HDR_LEN - ARP_BODY_BYTES;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0] HDR_LAST = 8'(HDR_LEN - 1);
  localparam logic [7:0] ARP_LAST = 8'(ARP_BODY_BYTES - 1);
  localparam logic [7:0] PAD_LAST = 8'(PAD_LEN - 1);
  localparam logic [7:0] FCS_LAST = 8'(FCS_BYTES - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  arp_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  mac_address  da_q, da_d, sa_q, sa_d, tha_q, tha_d;
  ip_address   spa_q, spa_d, tpa_q, tpa_d;
  arp_operator oper_q, oper_d;
  vlan_tci_t   tci_q, tci_d;

  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        crc_clr, crc_en;
  logic [7:0]  fcs_byte;

  logic [143:0] hdr_vec;
  logic [223:0] arp_vec;
  logic [7:0]   hdr_lsb, arp_lsb;
  logic [7:0]   hdr_byte, arp_byte;

  // Without VLAN the tag trails the 14 header bytes, so it is never shifted onto the wire.
  always_comb begin
    if (VLAN_EN) begin
      hdr_vec = {da_q, sa_q, ETHERTYPE_VLAN, tci_q, ETHERTYPE_ARP};
    end else begin
      hdr_vec = {da_q, sa_q, ETHERTYPE_ARP, ETHERTYPE_VLAN, tci_q};
    end
    arp_vec  = {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, oper_q,
                sa_q, spa_q, tha_q, tpa_q};
    hdr_lsb  = 8'd136 - {cnt_q[4:0], 3'b000};
    arp_lsb  = 8'd216 - {cnt_q[4:0], 3'b000};
    hdr_byte = hdr_vec[hdr_lsb +: 8];
    arp_byte = arp_vec[arp_lsb +: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    da_d    = da_q;
    sa_d    = sa_q;
    tha_d   = tha_q;
    spa_d   = spa_q;
    tpa_d   = tpa_q;
    oper_d  = oper_q;
    tci_d   = tci_q;
    tx_en_d = 1'b0;
    txd_d   = 8'h00;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    accept  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = req;
        cnt_d  = 8'd0;
        if (req) begin
          accept  = 1'b1;
          state_d = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = PREAMBLE_BYTE;
        if (cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
          cnt_d   = 8'd0;
        end
      end
      ST_SFD: begin
        tx_en_d = 1'b1;
        txd_d   = SFD_BYTE;
        crc_clr = 1'b1;
        state_d = ST_HDR;
        cnt_d   = 8'd0;
      end
      ST_HDR: begin
        tx_en_d = 1'b1;
        txd_d   = hdr_byte;
        crc_en  = 1'b1;
        if (cnt_q == HDR_LAST) begin
          state_d = ST_ARP;
          cnt_d   = 8'd0;
        end
      end
      ST_ARP: begin
        tx_en_d = 1'b1;
        txd_d   = arp_byte;
        crc_en  = 1'b1;
        if (cnt_q == ARP_LAST) begin
          state_d = ST_PAD;
          cnt_d   = 8'd0;
        end
      end
      ST_PAD: begin
        tx_en_d = 1'b1;
        crc_en  = 1'b1;
        if (cnt_q == PAD_LAST) begin
          state_d = ST_FCS;
          cnt_d   = 8'd0;
        end
      end
      ST_FCS: begin
        tx_en_d = 1'b1;
        txd_d   = fcs_byte;
        if (cnt_q == FCS_LAST) begin
          state_d = ST_IFG;
          cnt_d   = 8'd0;
        end
      end
      ST_IFG: begin
        done_d = (cnt_q == 8'd0);
        // Re-accept on the final gap cycle so back-to-back frames see exactly IFG_BYTES idles.
        if (cnt_q == IFG_LAST) begin
          cnt_d = 8'd0;
          if (req) begin
            accept  = 1'b1;
            state_d = ST_PREAMBLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    if (accept) begin
      da_d   = (operator == 16'd1) ? 48'hFFFF_FFFF_FFFF : des_mac_add;
      tha_d  = (operator == 16'd1) ? 48'h0000_0000_0000 : des_mac_add;
      sa_d   = src_mac_add;
      spa_d  = src_ip_add;
      tpa_d  = des_ip_add;
      oper_d = operator;
      tci_d  = vlan_tci;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      da_q    <= '0;
      sa_q    <= '0;
      tha_q   <= '0;
      spa_q   <= '0;
      tpa_q   <= '0;
      oper_q  <= '0;
      tci_q   <= '0;
      tx_en_q <= 1'b0;
      txd_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      da_q    <= da_d;
      sa_q    <= sa_d;
      tha_q   <= tha_d;
      spa_q   <= spa_d;
      tpa_q   <= tpa_d;
      oper_q  <= oper_d;
      tci_q   <= tci_d;
      tx_en_q <= tx_en_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  arp_frame_generator_param_fcs_gen u_fcs (
    .clk      (clk),
    .rst      (rst),
    .clr      (crc_clr),
    .en       (crc_en),
    .data     (txd_d),
    .idx      (cnt_q[1:0]),
    .fcs_byte (fcs_byte)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;
  assign gmii_tx_er = 1'b0;

endmodule
